// File: rtl/manchester_pkg.sv
// manchester_pkg: Manchester symbols shared with the escaper, arbiter defaults and state encoding.
package manchester_pkg;
    localparam logic [7:0] START_WORD          = 8'hD5;
    localparam logic [7:0] ESCAPE_SYMBOL       = 8'hE5;
    localparam logic [7:0] REPLACE_SYMBOL      = 8'hF5;
    localparam logic [7:0] HEADER_BASE_DEFAULT = 8'h40;
    typedef enum logic [2:0] {IDLE, HEADER, DATA, TRAILER, DONE} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after the last grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_hit,
    output logic [IW-1:0] o_grant
);
    // Scan farthest-first so the nearest requester after i_last is assigned last and wins.
    always_comb begin
        o_hit   = 1'b0;
        o_grant = i_last;
        for (int k = N; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % N]) begin
                o_hit   = 1'b1;
                o_grant = IW'((int'(i_last) + k) % N);
            end
        end
    end
endmodule

// File: rtl/manchester_tx_arbiter.sv
// manchester_tx_arbiter: round-robin frame arbiter adding a channel header in front of the Manchester escaper.
// Define MANCH_ARB_LEN_TRAILER_EN to append a payload-length trailer byte to every frame.
module manchester_tx_arbiter
    import manchester_pkg::*;
#(
    parameter int                    NUM_SRC     = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] HEADER_BASE = DATA_WIDTH'(HEADER_BASE_DEFAULT)
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_SRC-1:0]               s_axis_tvalid,
    input  logic [NUM_SRC-1:0]               s_axis_tlast,
    output logic [NUM_SRC-1:0]               s_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0]       grant_idx,
    output logic                             busy
);
    localparam int IW = $clog2(NUM_SRC);

    arb_state_t            r_state, w_next_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid, r_last, r_busy;
    logic [IW-1:0]         r_grant, w_next_grant;
    logic                  w_load, w_hit, w_take, w_src_valid, w_src_last, w_fwd_last;
    logic [DATA_WIDTH-1:0] w_src_data;
    arb_state_t            w_after_data;

    assign w_load      = !r_valid || m_axis_tready;
    assign w_src_valid = s_axis_tvalid[r_grant];
    assign w_src_last  = s_axis_tlast[r_grant];
    assign w_src_data  = s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_take      = s_axis_tready[r_grant] && w_src_valid;

`ifdef MANCH_ARB_LEN_TRAILER_EN
    logic [7:0] r_count;
    assign w_fwd_last   = 1'b0;
    assign w_after_data = TRAILER;
    always_ff @(posedge aclk) begin
        if (areset || r_state == HEADER)
            r_count <= '0;
        else if (w_take)
            r_count <= r_count + 8'd1;
    end
`else
    assign w_fwd_last   = w_src_last;
    assign w_after_data = DONE;
`endif

    rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_rr (
        .i_req   (s_axis_tvalid),
        .i_last  (r_grant),
        .o_hit   (w_hit),
        .o_grant (w_next_grant)
    );

    always_ff @(posedge aclk) begin
        if (areset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = (w_hit && w_load) ? HEADER : IDLE;
            HEADER:  w_next_state = w_load ? DATA : HEADER;
            DATA:    w_next_state = (w_take && w_src_last) ? w_after_data : DATA;
            TRAILER: w_next_state = w_load ? DONE : TRAILER;
            DONE:    w_next_state = (r_valid && m_axis_tready) ? IDLE : DONE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready          = '0;
        s_axis_tready[r_grant] = !areset && r_state == DATA && w_load;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_grant <= IW'(NUM_SRC - 1);
        end else begin
            if (r_state == IDLE && w_hit && w_load)
                r_grant <= w_next_grant;
            if (r_state == HEADER && w_load) begin
                r_data  <= HEADER_BASE + DATA_WIDTH'(r_grant);
                r_valid <= 1'b1;
                r_last  <= 1'b0;
                r_busy  <= 1'b1;
            end else if (w_take) begin
                r_data  <= w_src_data;
                r_valid <= 1'b1;
                r_last  <= w_fwd_last;
`ifdef MANCH_ARB_LEN_TRAILER_EN
            end else if (r_state == TRAILER && w_load) begin
                r_data  <= DATA_WIDTH'(r_count);
                r_valid <= 1'b1;
                r_last  <= 1'b1;
`endif
            end else if (w_load) begin
                r_valid <= 1'b0;
            end
            if (r_state == DONE && r_valid && m_axis_tready)
                r_busy <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_data;
    assign m_axis_tvalid = r_valid;
    assign m_axis_tlast  = r_last;
    assign grant_idx     = r_grant;
    assign busy          = r_busy;
endmodule

// File: tb/tb_manchester_tx_arbiter.sv
// tb_manchester_tx_arbiter: randomized scoreboard bench for the round-robin Manchester transmit arbiter.
module tb_manchester_tx_arbiter;
    localparam int         N  = 4;
    localparam int         DW = 8;
    localparam logic [7:0] HB = 8'h40;
`ifdef MANCH_ARB_LEN_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    typedef struct packed {logic [7:0] data; logic last; logic first;} beat_t;
    typedef struct packed {logic [7:0] data; logic last; logic hdr; logic [1:0] src;} exp_t;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [N*DW-1:0] s_axis_tdata = '0;
    logic [N-1:0]  s_axis_tvalid = '0;
    logic [N-1:0]  s_axis_tlast = '0;
    logic [N-1:0]  s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [1:0]    grant_idx;
    logic          busy;

    int    n_chk = 0, n_err = 0, pay_cnt = 0, m_last = N - 1;
    bit    rand_rdy = 0, bubble_en = 0, busy_chk = 0, prev_stall = 0;
    bit    hs[N];
    logic [7:0] prev_data;
    logic  prev_last;
    beat_t src_q[N][$];
    beat_t stg[N][$];
    exp_t  exp_q[$];
    exp_t  e;

    always #5 aclk = ~aclk;

    manchester_tx_arbiter dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_idx     (grant_idx),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic add_beat(input int s, input logic [7:0] d, input bit first, input bit last);
        beat_t b;
        b.data = d; b.last = last; b.first = first;
        stg[s].push_back(b);
    endtask

    task automatic add_rand_frame(input int s, input int len);
        for (int i = 0; i < len; i++) add_beat(s, 8'($urandom), i == 0, i == len - 1);
    endtask

    // Reference: serve whole pending frames in round-robin order after the last served source.
    task automatic launch();
        int nfr[N];
        int pos[N];
        int tot, s, cnt;
        exp_t x;
        tot = 0;
        for (int i = 0; i < N; i++) begin
            nfr[i] = 0; pos[i] = 0;
            foreach (stg[i][j]) if (stg[i][j].last) nfr[i]++;
            tot += nfr[i];
        end
        while (tot > 0) begin
            s = -1;
            for (int k = 1; k <= N; k++)
                if (s < 0 && nfr[(m_last + k) % N] > 0) s = (m_last + k) % N;
            m_last = s; nfr[s]--; tot--;
            x.data = HB + 8'(s); x.last = 1'b0; x.hdr = 1'b1; x.src = 2'(s);
            exp_q.push_back(x);
            cnt = 0;
            do begin
                x.data = stg[s][pos[s]].data; x.last = stg[s][pos[s]].last && !TRL; x.hdr = 1'b0;
                exp_q.push_back(x);
                cnt++; pos[s]++;
            end while (!stg[s][pos[s]-1].last);
            if (TRL) begin
                x.data = 8'(cnt); x.last = 1'b1; x.hdr = 1'b0;
                exp_q.push_back(x);
            end
        end
        for (int i = 0; i < N; i++) begin
            foreach (stg[i][j]) src_q[i].push_back(stg[i][j]);
            stg[i].delete();
        end
    endtask

    function automatic bit pending();
        pending = 1'b0;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pending = 1'b1;
    endfunction

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        do begin
            @(negedge aclk);
            c++;
        end while ((exp_q.size() > 0 || busy || pending()) && c < 5000);
        n_chk++;
        if (c >= 5000) begin
            n_err++;
            $display("FAIL %s drain timeout left %0d want 0", name, exp_q.size());
        end
    endtask

    task automatic run(input string name);
        @(posedge aclk); #2;
        launch();
        wait_drain(name);
    endtask

    // Source and downstream-ready driver: handshakes sampled at negedge, inputs updated just after posedge.
    initial begin
        bit tv;
        forever begin
            @(negedge aclk);
            for (int i = 0; i < N; i++) hs[i] = s_axis_tready[i] && s_axis_tvalid[i];
            @(posedge aclk); #1;
            for (int i = 0; i < N; i++) if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            m_axis_tready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
            for (int i = 0; i < N; i++) begin
                tv = src_q[i].size() > 0;
                if (tv && !src_q[i][0].first && bubble_en && $urandom_range(3) == 0) tv = 1'b0;
                s_axis_tvalid[i] = tv;
                s_axis_tdata[i*DW +: DW] = tv ? src_q[i][0].data : 8'($urandom);
                s_axis_tlast[i] = tv ? src_q[i][0].last : 1'($urandom_range(1));
            end
        end
    end

    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
            busy_chk = 1'b0;
        end else begin
            chk("tready_only_granted", 32'(s_axis_tready & ~(4'b0001 << grant_idx)), 32'd0);
            if (busy_chk) chk("busy_clear", 32'(busy), 32'd0);
            busy_chk = 1'b0;
            if (prev_stall) begin
                chk("hold_data", 32'(m_axis_tdata), 32'(prev_data));
                chk("hold_last", 32'(m_axis_tlast), 32'(prev_last));
                chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat got %0h want none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tdata, m_axis_tlast} !== {e.data, e.last}) begin
                        n_err++;
                        $display("FAIL beat got %0h/%0b want %0h/%0b", m_axis_tdata, m_axis_tlast, e.data, e.last);
                    end
                    chk("busy_in_frame", 32'(busy), 32'd1);
                    if (e.hdr) chk("grant_idx", 32'(grant_idx), 32'(e.src));
                    else pay_cnt++;
                    busy_chk = e.last;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
        end
    end

    initial begin
        int c;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        @(posedge aclk); #2 areset = 1'b0;
        @(negedge aclk);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);

        add_beat(1, 8'h11, 1, 0);
        add_beat(1, 8'h22, 0, 1);
        run("single_src1");
        chk("grant_after_src1", 32'(grant_idx), 32'd1);

        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) add_rand_frame(s, 2);
        run("all_sources");

        rand_rdy = 1; bubble_en = 1;
        add_rand_frame(2, 16);
        run("stall_src2");
        rand_rdy = 0; bubble_en = 0;

        add_beat(0, 8'hD5, 1, 1);
        run("one_byte_d5");

        pay_cnt = 0;
        add_rand_frame(2, 8);
        @(posedge aclk); #2;
        launch();
        c = 0;
        while (pay_cnt < 3 && c < 200) begin
            @(negedge aclk);
            c++;
        end
        chk("midframe_progress", 32'(c >= 200), 32'd0);
        @(posedge aclk); #2;
        areset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        s_axis_tvalid = '0;
        m_last = N - 1;
        @(posedge aclk); #2 areset = 1'b0;
        @(negedge aclk);
        chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grant", 32'(grant_idx), 32'd3);
        add_rand_frame(3, 3);
        add_rand_frame(0, 2);
        run("after_reset");

        rand_rdy = 1; bubble_en = 1;
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < N; s++) begin
                int nf;
                nf = $urandom_range(2);
                for (int f = 0; f < nf; f++) add_rand_frame(s, $urandom_range(1, 6));
            end
            run("random_round");
        end

        bubble_en = 0;
        add_rand_frame(3, 300);
        run("long_src3");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
